instr_fetch: RTL and testbench

Instruction fetch stage for the RISC-V core. It holds the PC and issues word requests to instruction memory over a req/ack handshake. It delivers each instruction with its address through a valid/stall output register; that instruction word drives the immediate generator, decoder and register file. Redirects from resolved branches/jumps are applied here, including discarding an in-flight fetch.

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/fetch_skid_buf.sv | 35 +++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, text-segment base and word-address helpers.
package instr_fetch_pkg;

  localparam logic [31:0] TEXT_BASE        = 32'h0040_0000;
  localparam int          INSTR_WORD_BYTES = 4;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_IDLE = 2'd0;
  localparam fetch_state_t S_REQ  = 2'd1;
  localparam fetch_state_t S_FULL = 2'd2;
  localparam fetch_state_t S_DROP = 2'd3;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'(INSTR_WORD_BYTES);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction word and its address while the output slot is stalled.
module fetch_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [31:0]       load_pc,
  output logic [DATA_W-1:0] instr,
  output logic [31:0]       pc,
  output logic              valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clear || unload) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload is only meaningful while valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/ack memory handshake, valid/stall output slot and redirect handling.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = TEXT_BASE
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStall,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemAck,
  input  logic [31:0] iMemData,
  output logic [31:0] oInstrucao,
  output logic [31:0] oPC,
  output logic        oValid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  target;
  logic         consume;
  logic         slot_free;
  logic         skid_load;
  logic         skid_unload;
  logic         skid_valid;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;

  assign consume     = oValid && !iStall;
  assign slot_free   = !oValid || !iStall;
  assign target      = word_align(iRedirectPC);
  assign oMemReq     = (state == S_REQ) || (state == S_DROP);
  assign skid_load   = !iRedirect && (state == S_REQ) && iMemAck && !slot_free;
  assign skid_unload = !iRedirect && (state == S_FULL) && consume;

  fetch_skid_buf #(.DATA_W(32)) u_skid (
    .clk        (iCLK),
    .rst        (iRST),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (iRedirect),
    .load_instr (iMemData),
    .load_pc    (oMemAddr),
    .instr      (skid_instr),
    .pc         (skid_pc),
    .valid      (skid_valid)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      oMemAddr   <= 32'h0;
      oValid     <= 1'b0;
      oInstrucao <= 32'h0;
      oPC        <= 32'h0;
    end else begin
      if (consume) begin
        oValid <= 1'b0;
      end
      if (iRedirect) begin
        oValid <= 1'b0;
        // An outstanding request cannot be withdrawn; S_DROP swallows its ack.
        unique case (state)
          S_DROP: pc <= target;
          S_REQ: begin
            if (iMemAck) begin
              oMemAddr <= target;
              pc       <= next_word(target);
            end else begin
              state <= S_DROP;
              pc    <= target;
            end
          end
          default: begin
            state    <= S_REQ;
            oMemAddr <= target;
            pc       <= next_word(target);
          end
        endcase
      end else begin
        unique case (state)
          S_IDLE: begin
            state    <= S_REQ;
            oMemAddr <= pc;
            pc       <= next_word(pc);
          end
          S_REQ: begin
            if (iMemAck) begin
              if (slot_free) begin
                oInstrucao <= iMemData;
                oPC        <= oMemAddr;
                oValid     <= 1'b1;
                oMemAddr   <= pc;
                pc         <= next_word(pc);
              end else begin
                state <= S_FULL;
              end
            end
          end
          S_FULL: begin
            if (consume) begin
              oInstrucao <= skid_instr;
              oPC        <= skid_pc;
              oValid     <= skid_valid;
              state      <= S_REQ;
              oMemAddr   <= pc;
              pc         <= next_word(pc);
            end
          end
          S_DROP: begin
            if (iMemAck) begin
              state    <= S_REQ;
              oMemAddr <= pc;
              pc       <= next_word(pc);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random-latency memory, random stall/redirect, stream-level reference model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        iStall, iRedirect, iMemAck, oMemReq, oValid;
  logic [31:0] iRedirectPC, iMemData, oMemAddr, oInstrucao, oPC;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(TEXT_BASE)) dut (
    .iCLK(clk), .iRST(rst), .iStall(iStall), .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
    .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemAck(iMemAck), .iMemData(iMemData),
    .oInstrucao(oInstrucao), .oPC(oPC), .oValid(oValid)
  );

  int vectors = 0, miscompares = 0;
  int consumed = 0, ack_count = 0;
  int wait_mode = 0;
  int waits_left = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired or no expected entry at %0t", name, $time);
  endtask

  // Expected stream: consecutive words from the last restart point.
  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    gen_pc = start - (start % 32'd4);
    refill();
  endtask

  // Memory responder: acks each request after wait_mode (or random 0..3) wait cycles.
  initial begin
    iMemAck  = 1'b0;
    iMemData = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !oMemReq) begin
        iMemAck  = 1'b0;
        iMemData = $urandom;
        if (rst) waits_left = 0;
      end else if (waits_left == 0) begin
        iMemAck    = 1'b1;
        iMemData   = oMemAddr ^ KEY;
        ack_count++;
        waits_left = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
      end else begin
        iMemAck    = 1'b0;
        iMemData   = $urandom;
        waits_left--;
      end
    end
  end

  // Monitor: pops an expected address per consumed output and checks hold rules.
  logic        have_prev = 1'b0;
  logic        p_valid, p_stall, p_redirect, p_req, p_ack;
  logic [31:0] p_pc, p_instr, p_addr;
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev) begin
          if (p_redirect) begin
            check("valid_after_redirect", 32'(oValid), 32'd0);
          end else if (p_valid && p_stall) begin
            check("stall_hold_pc", oPC, p_pc);
            check("stall_hold_instr", oInstrucao, p_instr);
            check("stall_hold_valid", 32'(oValid), 32'd1);
          end
          if (p_req && !p_ack) begin
            check("req_held", 32'(oMemReq), 32'd1);
            check("addr_held", oMemAddr, p_addr);
          end
        end
        if (oValid && !iStall) begin
          if (exp_q.size() == 0) begin
            fail_now("scoreboard_empty");
          end else begin
            e = exp_q.pop_front();
            check("out_pc", oPC, e);
            check("out_instr", oInstrucao, e ^ KEY);
            consumed++;
          end
        end
        p_valid = oValid; p_stall = iStall; p_redirect = iRedirect;
        p_req = oMemReq; p_ack = iMemAck;
        p_pc = oPC; p_instr = oInstrucao; p_addr = oMemAddr;
        have_prev = 1'b1;
      end
    end
  end

  task automatic step(input logic stall, input logic redir, input logic [31:0] tgt);
    @(negedge clk);
    #2;
    iStall      = stall;
    iRedirect   = redir;
    iRedirectPC = redir ? tgt : $urandom;
    #2;
    if (redir) restart_stream(tgt);
    refill();
  endtask

  initial begin
    int c0, a0, n;
    bit found;
    rst = 1'b1;
    iStall = 1'b0; iRedirect = 1'b0; iRedirectPC = 32'h0;
    wait_mode = 0;
    restart_stream(TEXT_BASE);

    repeat (2) @(negedge clk);
    #2;
    check("rst_req", 32'(oMemReq), 32'd0);
    check("rst_addr", oMemAddr, 32'd0);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_instr", oInstrucao, 32'd0);
    check("rst_pc", oPC, 32'd0);

    rst = 1'b0;
    #1;
    check("idle_req", 32'(oMemReq), 32'd0);
    @(posedge clk);
    #1;
    check("first_req", 32'(oMemReq), 32'd1);
    check("first_addr", oMemAddr, TEXT_BASE);

    // Zero-wait memory: one instruction per cycle.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    c0 = consumed;
    repeat (10) step(1'b0, 1'b0, 32'h0);
    check("back_to_back", 32'(consumed - c0), 32'd10);

    // Three wait states: one ack every fourth cycle.
    wait_mode = 3;
    repeat (8) step(1'b0, 1'b0, 32'h0);
    a0 = ack_count;
    repeat (20) step(1'b0, 1'b0, 32'h0);
    check("wait3_acks", 32'(ack_count - a0), 32'd5);

    // Stall five cycles: only one word absorbed, then request drops.
    wait_mode = 0;
    repeat (4) step(1'b0, 1'b0, 32'h0);
    a0 = ack_count;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (i >= 2) check("stall_req_low", 32'(oMemReq), 32'd0);
    end
    check("stall_acks", 32'(ack_count - a0), 32'd1);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    // Redirect while a 2-wait fetch of 0x00400010 is outstanding.
    wait_mode = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (iMemAck) found = 1'b1;
    end
    if (!found) fail_now("wait_ack_bound");
    step(1'b0, 1'b1, 32'h0040_0010);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (oMemReq && oMemAddr == 32'h0040_0010 && !iMemAck) found = 1'b1;
    end
    if (!found) fail_now("fetch_0010_bound");
    step(1'b0, 1'b1, 32'h0040_0100);
    step(1'b0, 1'b0, 32'h0);
    check("drop_addr", oMemAddr, 32'h0040_0010);
    c0 = consumed;
    for (int i = 0; i < 20 && consumed == c0; i++) step(1'b0, 1'b0, 32'h0);
    if (consumed == c0) fail_now("after_drop_bound");

    // Redirect coinciding with an ack, unaligned target.
    wait_mode = 0;
    repeat (4) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0040_0203);
    step(1'b0, 1'b0, 32'h0);
    check("ack_redirect_addr", oMemAddr, 32'h0040_0200);
    check("ack_redirect_valid", 32'(oValid), 32'd0);
    repeat (4) step(1'b0, 1'b0, 32'h0);

    // PC wrap past the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_addr0", oMemAddr, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_addr1", oMemAddr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    check("wrap_addr2", oMemAddr, 32'h0000_0000);
    repeat (4) step(1'b0, 1'b0, 32'h0);

    // Random latency, stalls and redirects.
    wait_mode = -1;
    c0 = consumed;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] t;
      t = 32'h0040_0000 + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, t);
    end
    check("random_progress", 32'(consumed - c0 >= 300), 32'd1);

    // Asynchronous reset in the middle of a fetch.
    wait_mode = 2;
    repeat (5) step(1'b0, 1'b0, 32'h0);
    #3;
    rst = 1'b1;
    #1;
    check("async_req", 32'(oMemReq), 32'd0);
    check("async_addr", oMemAddr, 32'd0);
    check("async_valid", 32'(oValid), 32'd0);
    check("async_instr", oInstrucao, 32'd0);
    check("async_pc", oPC, 32'd0);
    restart_stream(TEXT_BASE);
    @(negedge clk);
    #2;
    rst = 1'b0;
    c0 = consumed;
    n = 0;
    repeat (30) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    check("post_reset_progress", 32'(consumed - c0 >= 5), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
